// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: board, cursor, turn, win/draw detection, and the 9-cell display code array.
// Latency: button actions take effect on the next edge; CONTROL_ARRAY lags the game state by one cycle; CHECK takes one cycle.
// Backpressure: none; buttons are single-cycle pulses and are dropped in CHECK and, except SELECT, in OVER. Macro TTT_CURSOR_WRAP_EN enables a toroidal cursor.
module ttt_game_ctrl #(
  parameter int START_CURSOR = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic        BTN_LEFT,
  input  logic        BTN_RIGHT,
  input  logic        BTN_SELECT,
  output logic [35:0] CONTROL_ARRAY,
  output logic        TURN,
  output logic        GAME_OVER,
  output logic [1:0]  WINNER,
  output logic [3:0]  MOVE_COUNT
);

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  localparam logic [3:0]  START    = 4'(START_CURSOR);
  localparam logic [35:0] CA_RESET = 36'd1 << (4 * START_CURSOR);

  logic [1:0]  state;
  logic [17:0] board;      // cell i at [2i+1:2i]: 0 empty, 1 cross, 2 circle
  logic [3:0]  cursor;

  logic [7:0]  x_lines;
  logic [7:0]  o_lines;
  logic [8:0]  win_cells;
  logic        mover_won;
  logic [1:0]  mark;
  logic        cell_empty;
  logic        at_top, at_bot, at_left, at_right;
  logic [3:0]  cur_up, cur_dn, cur_lt, cur_rt;
  logic [3:0]  wrap_up, wrap_dn, wrap_lt, wrap_rt;
  logic [35:0] ca_next;

  // Completed lines for one mark; bit order rows 0..2, columns 0..2, main diagonal, anti-diagonal.
  function automatic logic [7:0] lines_of(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] h;
    for (int i = 0; i < 9; i++) h[i] = (b[2*i +: 2] == m);
    lines_of = {h[2] & h[4] & h[6], h[0] & h[4] & h[8],
                h[2] & h[5] & h[8], h[1] & h[4] & h[7], h[0] & h[3] & h[6],
                h[6] & h[7] & h[8], h[3] & h[4] & h[5], h[0] & h[1] & h[2]};
  endfunction

  // Cells covered by any of the given completed lines.
  function automatic logic [8:0] cells_of(input logic [7:0] l);
    logic [8:0] c;
    c[0] = l[0] | l[3] | l[6];
    c[1] = l[0] | l[4];
    c[2] = l[0] | l[5] | l[7];
    c[3] = l[1] | l[3];
    c[4] = l[1] | l[4] | l[6] | l[7];
    c[5] = l[1] | l[5];
    c[6] = l[2] | l[3] | l[7];
    c[7] = l[2] | l[4];
    c[8] = l[2] | l[5] | l[6];
    cells_of = c;
  endfunction

  // Line detection, current-cell status and the winning cells to highlight in OVER.
  always_comb begin
    x_lines    = lines_of(board, 2'd1);
    o_lines    = lines_of(board, 2'd2);
    mover_won  = TURN ? (|o_lines) : (|x_lines);
    mark       = TURN ? 2'd2 : 2'd1;
    cell_empty = (board[{cursor, 1'b0} +: 2] == 2'd0);
    win_cells  = '0;
    if (WINNER == 2'd1)      win_cells = cells_of(x_lines);
    else if (WINNER == 2'd2) win_cells = cells_of(o_lines);
  end

  // Candidate cursor positions for each direction; edge moves either wrap or stay put.
  always_comb begin
    at_top   = (cursor < 4'd3);
    at_bot   = (cursor >= 4'd6);
    at_left  = (cursor == 4'd0) || (cursor == 4'd3) || (cursor == 4'd6);
    at_right = (cursor == 4'd2) || (cursor == 4'd5) || (cursor == 4'd8);
`ifdef TTT_CURSOR_WRAP_EN
    wrap_up = cursor + 4'd6;
    wrap_dn = cursor - 4'd6;
    wrap_lt = cursor + 4'd2;
    wrap_rt = cursor - 4'd2;
`else
    wrap_up = cursor;
    wrap_dn = cursor;
    wrap_lt = cursor;
    wrap_rt = cursor;
`endif
    cur_up = at_top   ? wrap_up : cursor - 4'd3;
    cur_dn = at_bot   ? wrap_dn : cursor + 4'd3;
    cur_lt = at_left  ? wrap_lt : cursor - 4'd1;
    cur_rt = at_right ? wrap_rt : cursor + 4'd1;
  end

  // Game state machine: moves and marks in PLAY, verdict in CHECK, restart from OVER.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_PLAY;
      board      <= '0;
      cursor     <= START;
      TURN       <= 1'b0;
      WINNER     <= 2'd0;
      MOVE_COUNT <= 4'd0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (BTN_SELECT) begin
            if (cell_empty) begin
              board[{cursor, 1'b0} +: 2] <= mark;
              MOVE_COUNT <= MOVE_COUNT + 4'd1;
              state      <= ST_CHECK;
            end
          end else if (BTN_UP) begin
            cursor <= cur_up;
          end else if (BTN_DOWN) begin
            cursor <= cur_dn;
          end else if (BTN_LEFT) begin
            cursor <= cur_lt;
          end else if (BTN_RIGHT) begin
            cursor <= cur_rt;
          end
        end
        ST_CHECK: begin
          // A win on the ninth move beats the draw.
          if (mover_won) begin
            WINNER <= TURN ? 2'd2 : 2'd1;
            state  <= ST_OVER;
          end else if (MOVE_COUNT == 4'd9) begin
            WINNER <= 2'd3;
            state  <= ST_OVER;
          end else begin
            TURN  <= ~TURN;
            state <= ST_PLAY;
          end
        end
        ST_OVER: begin
          if (BTN_SELECT) begin
            state      <= ST_PLAY;
            board      <= '0;
            cursor     <= START;
            TURN       <= 1'b0;
            WINNER     <= 2'd0;
            MOVE_COUNT <= 4'd0;
          end
        end
        default: state <= ST_PLAY;
      endcase
    end
  end

  // Per-cell display code: mark base plus cursor marker, or winning-line highlight once the game is over.
  always_comb begin
    ca_next = '0;
    for (int i = 0; i < 9; i++) begin
      logic [3:0] base;
      case (board[2*i +: 2])
        2'd1:    base = 4'd3;
        2'd2:    base = 4'd6;
        default: base = 4'd0;
      endcase
      if (state == ST_OVER) begin
        if (win_cells[i]) ca_next[4*i +: 4] = (WINNER == 2'd2) ? 4'd8 : 4'd4;
        else              ca_next[4*i +: 4] = base;
      end else begin
        ca_next[4*i +: 4] = base + ((cursor == 4'(i)) ? (TURN ? 4'd2 : 4'd1) : 4'd0);
      end
    end
  end

  // Display register: one cycle behind the game state so the consumer sees a stable frame.
  always_ff @(posedge CLK) begin
    if (RESET) CONTROL_ARRAY <= CA_RESET;
    else       CONTROL_ARRAY <= ca_next;
  end

  assign GAME_OVER = (state == ST_OVER);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: reset, cursor moves and wrap, marking, win/draw verdicts, restart.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected display words are hand-computed hex constants (cell 8 is the leftmost nibble).
module tb_ttt_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn;   // {select, up, down, left, right}
  logic [35:0] control_array;
  logic        turn;
  logic        game_over;
  logic [1:0]  winner;
  logic [3:0]  move_count;

  int n_chk  = 0;
  int n_fail = 0;
  int cur    = 4;

  localparam logic [4:0] B_SEL = 5'b10000;
  localparam logic [4:0] B_UP  = 5'b01000;
  localparam logic [4:0] B_DN  = 5'b00100;
  localparam logic [4:0] B_LT  = 5'b00010;
  localparam logic [4:0] B_RT  = 5'b00001;

  ttt_game_ctrl #(.START_CURSOR(4)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .BTN_UP        (btn[3]),
    .BTN_DOWN      (btn[2]),
    .BTN_LEFT      (btn[1]),
    .BTN_RIGHT     (btn[0]),
    .BTN_SELECT    (btn[4]),
    .CONTROL_ARRAY (control_array),
    .TURN          (turn),
    .GAME_OVER     (game_over),
    .WINNER        (winner),
    .MOVE_COUNT    (move_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [4:0] b);
    btn = b;
    @(negedge clk);
    btn = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur = 4;
  endtask

  task automatic goto(input int tgt);
    while (cur / 3 > tgt / 3) begin pulse(B_UP); cur -= 3; end
    while (cur / 3 < tgt / 3) begin pulse(B_DN); cur += 3; end
    while (cur % 3 > tgt % 3) begin pulse(B_LT); cur -= 1; end
    while (cur % 3 < tgt % 3) begin pulse(B_RT); cur += 1; end
  endtask

  // Place a mark at cell c and let the one-cycle CHECK complete.
  task automatic play(input int c);
    goto(c);
    pulse(B_SEL);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    btn = '0;
    idle(2);
    chk("rst_ca",     control_array, 36'h000010000);
    chk("rst_turn",   turn,          0);
    chk("rst_over",   game_over,     0);
    chk("rst_winner", winner,        0);
    chk("rst_count",  move_count,    0);

    // First button in the cycle RESET drops; display lags one cycle.
    rst = 1'b0;
    btn = B_RT;
    @(negedge clk);
    btn = '0;
    cur = 5;
    chk("right_lag", control_array, 36'h000010000);
    idle(1);
    chk("right_ca",  control_array, 36'h000100000);

    // Mark cell 4, then reselect it on circle's turn.
    pulse(B_LT); cur = 4;
    pulse(B_SEL);
    chk("sel1_count", move_count, 1);
    chk("sel1_check_turn", turn, 0);
    idle(1);
    chk("sel1_turn", turn, 1);
    idle(1);
    chk("sel1_ca", control_array, 36'h000050000);
    pulse(B_SEL);
    idle(2);
    chk("sel2_count", move_count, 1);
    chk("sel2_turn",  turn, 1);
    chk("sel2_ca",    control_array, 36'h000050000);

    // UP beats DOWN when both pulse together.
    pulse(B_UP | B_DN); cur = 1;
    idle(1);
    chk("prio_ca", control_array, 36'h000030020);

    // Cross wins the top row.
    do_reset();
    play(0); play(3); play(1); play(4); play(2);
    chk("xwin_over",   game_over,  1);
    chk("xwin_winner", winner,     1);
    chk("xwin_count",  move_count, 5);
    idle(1);
    chk("xwin_ca", control_array, 36'h000066444);
    pulse(B_UP);
    idle(1);
    chk("over_ign_ca",   control_array, 36'h000066444);
    chk("over_ign_over", game_over, 1);
    do_reset();
    chk("over_rst_over", game_over, 0);

    // Ninth move completes column 0: win beats draw.
    play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(8); play(6);
    chk("win9_winner", winner,     1);
    chk("win9_count",  move_count, 9);
    idle(1);
    chk("win9_ca", control_array, 36'h634664364);

    // Nine-move draw, then restart.
    do_reset();
    play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6); play(8);
    chk("draw_over",   game_over,  1);
    chk("draw_winner", winner,     3);
    chk("draw_count",  move_count, 9);
    idle(1);
    chk("draw_ca", control_array, 36'h336663363);
    pulse(B_SEL); cur = 4;
    chk("restart_count",  move_count, 0);
    chk("restart_winner", winner,     0);
    chk("restart_over",   game_over,  0);
    chk("restart_turn",   turn,       0);
    idle(1);
    chk("restart_ca", control_array, 36'h000010000);

    // Edge behaviour of the cursor.
    goto(2);
    pulse(B_RT);
    idle(1);
`ifdef TTT_CURSOR_WRAP_EN
    chk("edge_right", control_array, 36'h000000001); cur = 0;
`else
    chk("edge_right", control_array, 36'h000000100); cur = 2;
`endif
    goto(0);
    pulse(B_UP);
    idle(1);
`ifdef TTT_CURSOR_WRAP_EN
    chk("edge_up", control_array, 36'h001000000); cur = 6;
`else
    chk("edge_up", control_array, 36'h000000001); cur = 0;
`endif

    // UP and SELECT together: mark placed, cursor stays.
    goto(4);
    pulse(B_UP | B_SEL);
    chk("upsel_count", move_count, 1);
    idle(1);
    chk("upsel_turn", turn, 1);
    idle(1);
    chk("upsel_ca", control_array, 36'h000050000);

    // RESET while in CHECK.
    pulse(B_LT); cur = 3;
    btn = B_SEL;
    @(negedge clk);
    btn = '0;
    chk("chk_count", move_count, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_count",  move_count, 0);
    chk("midrst_turn",   turn,       0);
    chk("midrst_over",   game_over,  0);
    chk("midrst_winner", winner,     0);
    chk("midrst_ca",     control_array, 36'h000010000);
    rst = 1'b0;
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
